// File: rtl/if_pc_stage.sv
// ============================================================================
// if_pc_stage : instruction-fetch PC stage with 1-entry skid to decode.
// Optional perf counters enabled by defining IF_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module if_pc_stage #(
  parameter int unsigned     AW       = 10,
  parameter int unsigned     DW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] pc_plus1,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [DW-1:0] id_inst,
  output logic [AW-1:0] id_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_redirect_cnt
`endif
);

  logic [AW-1:0] pc_q, pc_d;
  logic          infl_q, infl_d;
  logic [AW-1:0] infl_pc_q, infl_pc_d;
  logic          id_valid_q, id_valid_d;
  logic [DW-1:0] id_inst_q, id_inst_d;
  logic [AW-1:0] id_pc_q, id_pc_d;
  logic          skid_v_q, skid_v_d;
  logic [DW-1:0] skid_inst_q, skid_inst_d;
  logic [AW-1:0] skid_pc_q, skid_pc_d;

  logic          deq;
  logic [1:0]    occ;
  logic [2:0]    occ_after;
  logic          issue;

  assign deq       = id_valid_q & id_ready;
  assign occ       = {1'b0, infl_q} + {1'b0, id_valid_q} + {1'b0, skid_v_q};
  assign occ_after = {1'b0, occ} - {2'b00, deq};
  // At most two words may be owned downstream of the PC (output + skid).
  assign issue     = ~rst & ~redirect_valid & (occ_after < 3'd2);

  assign pc_plus1  = pc_q + {{(AW-1){1'b0}}, 1'b1};
  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;

  always_comb begin
    pc_d        = pc_q;
    infl_d      = 1'b0;
    infl_pc_d   = infl_pc_q;
    id_valid_d  = id_valid_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    skid_v_d    = skid_v_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
      skid_v_d   = 1'b0;
    end else begin
      if (issue) begin
        pc_d      = pc_plus1;
        infl_d    = 1'b1;
        infl_pc_d = pc_q;
      end
      if (deq) begin
        if (skid_v_q) begin
          id_inst_d = skid_inst_q;
          id_pc_d   = skid_pc_q;
          skid_v_d  = 1'b0;
        end else begin
          id_valid_d = 1'b0;
        end
      end
      // The arriving word goes to the output only if that slot frees up this cycle.
      if (infl_q) begin
        if (!id_valid_q || (deq && !skid_v_q)) begin
          id_valid_d = 1'b1;
          id_inst_d  = imem_rdata;
          id_pc_d    = infl_pc_q;
        end else begin
          skid_v_d    = 1'b1;
          skid_inst_d = imem_rdata;
          skid_pc_d   = infl_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      infl_q      <= 1'b0;
      infl_pc_q   <= '0;
      id_valid_q  <= 1'b0;
      id_inst_q   <= '0;
      id_pc_q     <= '0;
      skid_v_q    <= 1'b0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      infl_q      <= infl_d;
      infl_pc_q   <= infl_pc_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      skid_v_q    <= skid_v_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, deq};
    redir_cnt_d = redir_cnt_q + {31'd0, redirect_valid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_redirect_cnt = redir_cnt_q;
`endif

endmodule

`default_nettype wire
